// File: rtl/weight_fifo_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : weight_fifo_in_ctrl
// Description : Write-side controller for the weight FIFO bank. Loads one
//               tile of SYS_ROW rows into FIFO_WIDTH parallel lanes, tracks
//               occupancy, and pulses out_en once a full tile is resident.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_fifo_in_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          fifo_pop_i,
  output logic [FIFO_WIDTH-1:0]         fifo_wen_o,
  output logic [$clog2(FIFO_DEPTH):0]   occ_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          out_en_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(SYS_ROW) + 1;

  localparam logic [OCC_W-1:0] DEPTH_V    = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_ROW_V = CNT_W'(SYS_ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_LOADED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  logic             push;
  logic             pop_eff;
  logic             in_ready;

  // Handshake and write-enable decode; a pop never frees a slot in the same cycle.
  always_comb begin
    in_ready = (state_q == S_FILL) && (occ_q < DEPTH_V);
    push     = (state_q == S_FILL) && in_valid_i && in_ready;
    pop_eff  = fifo_pop_i && (occ_q != '0);
  end

  // Next-state, row counter, occupancy and sticky error logic.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    occ_d     = occ_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FILL;
          row_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (push) begin
          if (row_cnt_q == LAST_ROW_V) begin
            state_d   = S_LOADED;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOADED: begin
        // A start seen here is dropped; the source reissues it once idle.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        row_cnt_d = '0;
      end
    endcase

    case ({push, pop_eff})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // Protocol violations: start while busy, or pop from an empty FIFO.
    if ((start_i && (state_q != S_IDLE)) || (fifo_pop_i && (occ_q == '0))) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  // Output decode.
  always_comb begin
    in_ready_o = in_ready;
    fifo_wen_o = {FIFO_WIDTH{push}};
    occ_o      = occ_q;
    full_o     = (occ_q == DEPTH_V);
    empty_o    = (occ_q == '0);
    out_en_o   = (state_q == S_LOADED);
    busy_o     = (state_q != S_IDLE);
    err_o      = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_fifo_in_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_fifo_in_ctrl
// Description : Directed self-checking bench for weight_fifo_in_ctrl
//               (SYS_ROW = FIFO_WIDTH = FIFO_DEPTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_fifo_in_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_pop;
  logic [15:0] fifo_wen;
  logic [4:0]  occ;
  logic        full;
  logic        empty;
  logic        out_en;
  logic        busy;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  weight_fifo_in_ctrl #(
    .SYS_ROW    (16),
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .fifo_pop_i (fifo_pop),
    .fifo_wen_o (fifo_wen),
    .occ_o      (occ),
    .full_o     (full),
    .empty_o    (empty),
    .out_en_o   (out_en),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point for outputs, away from the active edge.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bad;

    rstn     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    fifo_pop = 1'b0;
    tick();
    tick();

    // Reset output values
    smp();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fifo_wen", fifo_wen, 0);
    chk("rst_occ",      occ,      0);
    chk("rst_full",     full,     0);
    chk("rst_empty",    empty,    1);
    chk("rst_out_en",   out_en,   0);
    chk("rst_busy",     busy,     0);
    chk("rst_err",      err,      0);
    tick();
    rstn = 1'b1;
    tick();

    // Full tile with in_valid held high: pushes on cycles 1..16, out_en on 17
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      smp();
      if (fifo_wen === 16'hFFFF && in_ready === 1'b1 && out_en === 1'b0) n++;
      tick();
    end
    chk("A_push_cycles", n, 16);
    smp();
    chk("A_out_en_c17", out_en,   1);
    chk("A_wen_c17",    fifo_wen, 0);
    chk("A_occ_c17",    occ,      16);
    chk("A_full_c17",   full,     1);
    chk("A_busy_c17",   busy,     1);
    tick();
    smp();
    chk("A_busy_c18",   busy,   0);
    chk("A_out_en_c18", out_en, 0);
    chk("A_occ_c18",    occ,    16);
    chk("A_err_c18",    err,    0);
    tick();

    // Start into a full FIFO: blocked until one pop frees a slot
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      smp();
      if (in_ready === 1'b0 && fifo_wen === 16'h0000) n++;
      tick();
    end
    chk("C_blocked", n, 3);
    fifo_pop = 1'b1;
    smp();
    chk("C_no_bypass", in_ready, 0);
    tick();
    fifo_pop = 1'b0;
    smp();
    chk("C_occ_after_pop", occ,      15);
    chk("C_push_after_pop", fifo_wen, 16'hFFFF);
    tick();
    smp();
    chk("C_occ_refilled",  occ,      16);
    chk("C_ready_refull",  in_ready, 0);
    tick();

    // Drain to 8 entries, then push and pop together
    in_valid = 1'b0;
    fifo_pop = 1'b1;
    repeat (8) tick();
    fifo_pop = 1'b0;
    smp();
    chk("D_occ_drained", occ, 8);
    tick();
    in_valid = 1'b1;
    fifo_pop = 1'b1;
    smp();
    chk("D_push_with_pop", fifo_wen, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    fifo_pop = 1'b0;
    smp();
    chk("D_occ_steady", occ, 8);
    chk("D_err_clean",  err, 0);
    tick();

    // Start during FILL: flagged, fill continues
    start = 1'b1;
    tick();
    start = 1'b0;
    smp();
    chk("E_err_set",    err,      1);
    chk("E_still_fill", busy,     1);
    chk("E_ready",      in_ready, 1);
    tick();

    // Three more rows make five in this tile, then reset mid-fill
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    smp();
    chk("R_occ_before", occ, 11);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    smp();
    chk("R_occ",   occ,   0);
    chk("R_busy",  busy,  0);
    chk("R_err",   err,   0);
    chk("R_empty", empty, 1);
    tick();
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      smp();
      if (out_en !== 1'b0) bad++;
      tick();
    end
    chk("R_no_out_en", bad, 0);

    // Pop from empty: error, occupancy stays 0
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    smp();
    chk("F_err_set", err, 1);
    chk("F_occ",     occ, 0);
    tick();

    // Toggling in_valid: 16 accepted rows on odd cycles, out_en on cycle 32
    start = 1'b1;
    tick();
    start = 1'b0;
    n   = 0;
    bad = 0;
    for (int c = 1; c <= 31; c++) begin
      in_valid = c[0];
      smp();
      if (fifo_wen === 16'hFFFF) n++;
      if (out_en !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b1;
    smp();
    chk("B_pushes",      n,      16);
    chk("B_early_out",   bad,    0);
    chk("B_out_en_c32",  out_en, 1);
    chk("B_occ_c32",     occ,    16);
    tick();
    start = 1'b0;
    smp();
    chk("B_start_in_loaded_dropped", busy,   0);
    chk("B_out_en_c33",              out_en, 0);
    chk("B_err_sticky",              err,    1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
